regfile_8x16: RTL and testbench

Eight-entry general-purpose register file (R0–R7) for the LC-3 datapath. It is the consumer of the one-hot load-enable vector produced by the 3-to-8 destination-register decoder. On a clock edge it writes the bus value into the selected register, and it presents two combinational read ports addressed by SR1/SR2. It also re-encodes the one-hot vector into a destination index, so the control FSM and debug logic can see which register was last written, and it flags illegal multi-hot load vectors.

---
 rtl/regfile_8x16.sv | 65 ++++++
 tb/tb_regfile_8x16.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_8x16.sv
// LC-3 general-purpose register file: eight WIDTH-bit registers, one-hot write port, two combinational read ports.
// Optional macro REGFILE_BYPASS_EN forwards an accepted write's D_in to a read port addressing the same register.
module regfile_8x16 #(
   parameter int WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [7:0]       Ld_signals,
   input  logic [WIDTH-1:0] D_in,
   input  logic [2:0]       SR1,
   input  logic [2:0]       SR2,
   output logic [WIDTH-1:0] SR1_OUT,
   output logic [WIDTH-1:0] SR2_OUT,
   output logic [2:0]       Last_DR,
   output logic             Wr_valid,
   output logic             Ld_err
);

   // No handshake: a nonzero Ld_signals is a write request, and D_in is
   // guaranteed stable at that edge by the control FSM.

   logic [WIDTH-1:0] regs [8];
   logic             multi_hot;
   logic             one_hot;
   logic [2:0]       ld_idx;

   always_comb begin
      multi_hot = (Ld_signals & (Ld_signals - 8'd1)) != 8'd0;
      one_hot   = (Ld_signals != 8'd0) && !multi_hot;
   end

   // OR of the indices of all set bits; only meaningful when one_hot is true.
   always_comb begin
      ld_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (Ld_signals[i]) ld_idx = ld_idx | 3'(i);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
         Last_DR  <= 3'd0;
         Wr_valid <= 1'b0;
         Ld_err   <= 1'b0;
      end else begin
         Wr_valid <= one_hot;
         if (one_hot) begin
            regs[ld_idx] <= D_in;
            Last_DR      <= ld_idx;
         end
         if (multi_hot) Ld_err <= 1'b1;
      end
   end

   always_comb begin
      SR1_OUT = regs[SR1];
      SR2_OUT = regs[SR2];
`ifdef REGFILE_BYPASS_EN
      if (one_hot && (ld_idx == SR1)) SR1_OUT = D_in;
      if (one_hot && (ld_idx == SR2)) SR2_OUT = D_in;
`endif
   end

endmodule

// File: tb/tb_regfile_8x16.sv
// Directed bench for regfile_8x16: reset, single write, multi-hot rejection,
// read-during-write, reset-vs-write priority and back-to-back writes.
module tb_regfile_8x16;

   logic        clk;
   logic        reset;
   logic [7:0]  ld_signals;
   logic [15:0] d_in;
   logic [2:0]  sr1;
   logic [2:0]  sr2;
   logic [15:0] sr1_out;
   logic [15:0] sr2_out;
   logic [2:0]  last_dr;
   logic        wr_valid;
   logic        ld_err;

   int checks = 0;
   int errors = 0;

   regfile_8x16 #(.WIDTH(16)) dut (
      .Clk       (clk),
      .Reset     (reset),
      .Ld_signals(ld_signals),
      .D_in      (d_in),
      .SR1       (sr1),
      .SR2       (sr2),
      .SR1_OUT   (sr1_out),
      .SR2_OUT   (sr2_out),
      .Last_DR   (last_dr),
      .Wr_valid  (wr_valid),
      .Ld_err    (ld_err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver: present a load for one edge, then return to idle; results are
   // visible at the negedge following the sampling edge
   task automatic do_write(input logic [7:0] ld, input logic [15:0] d);
      @(negedge clk);
      ld_signals = ld;
      d_in       = d;
      @(negedge clk);
      ld_signals = 8'd0;
      d_in       = 16'd0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sr1 = 3'(i);
         sr2 = 3'(7 - i);
         #1;
         checks++;
         if (sr1_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_sr1[%0d]: got %h expected 0000", i, sr1_out);
         end
         checks++;
         if (sr2_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_sr2[%0d]: got %h expected 0000", 7 - i, sr2_out);
         end
      end
      checks++;
      if (last_dr !== 3'd0) begin
         errors++;
         $display("FAIL reset_last_dr: got %0d expected 0", last_dr);
      end
      checks++;
      if (wr_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_wr_valid: got %b expected 0", wr_valid);
      end
      checks++;
      if (ld_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_ld_err: got %b expected 0", ld_err);
      end
   endtask

   task automatic test_single_write;
      do_write(8'b0000_1000, 16'hBEEF);
      sr1 = 3'd3;
      sr2 = 3'd3;
      #1;
      checks++;
      if (sr1_out !== 16'hBEEF) begin
         errors++;
         $display("FAIL single_sr1: got %h expected beef", sr1_out);
      end
      checks++;
      if (sr2_out !== 16'hBEEF) begin
         errors++;
         $display("FAIL single_sr2: got %h expected beef", sr2_out);
      end
      checks++;
      if (last_dr !== 3'd3) begin
         errors++;
         $display("FAIL single_last_dr: got %0d expected 3", last_dr);
      end
      checks++;
      if (wr_valid !== 1'b1) begin
         errors++;
         $display("FAIL single_wr_valid_hi: got %b expected 1", wr_valid);
      end
      @(negedge clk);
      checks++;
      if (wr_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_wr_valid_lo: got %b expected 0", wr_valid);
      end
      for (int i = 0; i < 8; i++) begin
         if (i == 3) continue;
         sr1 = 3'(i);
         #1;
         checks++;
         if (sr1_out !== 16'h0000) begin
            errors++;
            $display("FAIL single_other[%0d]: got %h expected 0000", i, sr1_out);
         end
      end
   endtask

   task automatic test_multi_hot;
      do_write(8'b1000_0000, 16'h1234);
      do_write(8'b1000_0001, 16'hFFFF);
      sr1 = 3'd0;
      sr2 = 3'd7;
      #1;
      checks++;
      if (sr1_out !== 16'h0000) begin
         errors++;
         $display("FAIL multi_r0: got %h expected 0000", sr1_out);
      end
      checks++;
      if (sr2_out !== 16'h1234) begin
         errors++;
         $display("FAIL multi_r7: got %h expected 1234", sr2_out);
      end
      checks++;
      if (last_dr !== 3'd7) begin
         errors++;
         $display("FAIL multi_last_dr: got %0d expected 7", last_dr);
      end
      checks++;
      if (wr_valid !== 1'b0) begin
         errors++;
         $display("FAIL multi_wr_valid: got %b expected 0", wr_valid);
      end
      checks++;
      if (ld_err !== 1'b1) begin
         errors++;
         $display("FAIL multi_ld_err: got %b expected 1", ld_err);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (ld_err !== 1'b1) begin
            errors++;
            $display("FAIL multi_ld_err_sticky[%0d]: got %b expected 1", i, ld_err);
         end
      end
   endtask

   task automatic test_read_during_write;
      logic [15:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
      exp_pre = 16'h00A5;
`else
      exp_pre = 16'h0011;
`endif
      do_write(8'b0000_0100, 16'h0011);
      @(negedge clk);
      ld_signals = 8'b0000_0100;
      d_in       = 16'h00A5;
      sr2        = 3'd2;
      #1;
      checks++;
      if (sr2_out !== exp_pre) begin
         errors++;
         $display("FAIL rdw_before_edge: got %h expected %h", sr2_out, exp_pre);
      end
      @(negedge clk);
      ld_signals = 8'd0;
      d_in       = 16'd0;
      #1;
      checks++;
      if (sr2_out !== 16'h00A5) begin
         errors++;
         $display("FAIL rdw_after_edge: got %h expected 00a5", sr2_out);
      end
   endtask

   task automatic test_reset_with_write;
      do_write(8'b0010_0000, 16'h7777);
      @(negedge clk);
      reset      = 1'b1;
      ld_signals = 8'b0010_0000;
      d_in       = 16'h5555;
      @(negedge clk);
      reset      = 1'b0;
      ld_signals = 8'd0;
      d_in       = 16'd0;
      sr1        = 3'd5;
      #1;
      checks++;
      if (sr1_out !== 16'h0000) begin
         errors++;
         $display("FAIL rst_wr_r5: got %h expected 0000", sr1_out);
      end
      checks++;
      if (wr_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_wr_wr_valid: got %b expected 0", wr_valid);
      end
      checks++;
      if (last_dr !== 3'd0) begin
         errors++;
         $display("FAIL rst_wr_last_dr: got %0d expected 0", last_dr);
      end
      checks++;
      if (ld_err !== 1'b0) begin
         errors++;
         $display("FAIL rst_wr_ld_err: got %b expected 0", ld_err);
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checks++;
            if (wr_valid !== 1'b1 || last_dr !== 3'(i - 1)) begin
               errors++;
               $display("FAIL b2b_cycle[%0d]: got wr_valid=%b last_dr=%0d expected 1/%0d",
                        i - 1, wr_valid, last_dr, i - 1);
            end
         end
         ld_signals = 8'(1 << i);
         d_in       = 16'h1000 + 16'(i);
      end
      @(negedge clk);
      ld_signals = 8'd0;
      d_in       = 16'd0;
      checks++;
      if (wr_valid !== 1'b1 || last_dr !== 3'd7) begin
         errors++;
         $display("FAIL b2b_cycle[7]: got wr_valid=%b last_dr=%0d expected 1/7", wr_valid, last_dr);
      end
      @(negedge clk);
      checks++;
      if (wr_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_wr_valid_end: got %b expected 0", wr_valid);
      end
      for (int i = 0; i < 8; i++) begin
         sr1 = 3'(i);
         sr2 = 3'(i);
         #1;
         checks++;
         if (sr1_out !== 16'h1000 + 16'(i) || sr2_out !== 16'h1000 + 16'(i)) begin
            errors++;
            $display("FAIL b2b_read[%0d]: got %h/%h expected %h", i, sr1_out, sr2_out,
                     16'h1000 + 16'(i));
         end
      end
   endtask

   initial begin
      reset      = 1'b1;
      ld_signals = 8'd0;
      d_in       = 16'd0;
      sr1        = 3'd0;
      sr2        = 3'd0;
      test_reset();
      test_single_write();
      test_multi_hot();
      test_read_during_write();
      test_reset_with_write();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
